// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and ISA constants for the fetch stage
package fetch_unit_pkg;

  localparam int ISA_XLEN = 32;
  localparam logic [ISA_XLEN-1:0] ISA_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    READY,
    HALTED
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory req/ack port between fetch and memory
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int Width = ISA_XLEN
) ();

  logic             mem_req;
  logic [Width-1:0] mem_addr;
  logic             mem_ack;
  logic [31:0]      mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage holding the architectural PC
// Fetches at PC over a req/ack port, retires on advance, and obeys trap and debug redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               Width       = ISA_XLEN,
  parameter logic [Width-1:0] ResetVector = Width'(ISA_RESET_VECTOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic [Width-1:0] next_pc,
  input  logic             ialign,
  input  logic             trap_take,
  input  logic [Width-1:0] trap_pc,
  input  logic             halt_req,
  input  logic             resume_req,
  input  logic             dpc_we,
  input  logic [Width-1:0] dpc_wdata,
  output logic             halted,
  fetch_unit_if.master     mem,
  output logic [Width-1:0] pc,
  output logic [31:0]      inst,
  output logic             inst_valid,
  output logic             ialign_fault
);

  fetch_state_e     state, state_d;
  logic [Width-1:0] pc_d;
  logic [Width-1:0] req_addr, req_addr_d;
  logic [31:0]      inst_d;
  logic             mem_req_q;
  logic             inst_valid_q;
  logic             halted_q;
  logic             req_done;
  logic [Width-1:0] dpc_aligned;

  // An ack only counts while a request is actually on the bus (not in the first cycle after reset).
  assign req_done    = mem_req_q & mem.mem_ack;
  assign dpc_aligned = {dpc_wdata[Width-1:2], 2'b00};

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = req_addr;
  assign inst_valid   = inst_valid_q;
  assign halted       = halted_q;

  always_comb begin
    state_d      = state;
    pc_d         = pc;
    req_addr_d   = req_addr;
    inst_d       = inst;
    ialign_fault = 1'b0;

    unique case (state)
      FETCH: begin
        if (trap_take) begin
          pc_d = trap_pc;
          // With nothing left in flight we can retarget at once; otherwise wait out the old request.
          if (req_done || !mem_req_q) begin
            req_addr_d = trap_pc;
          end else begin
            state_d = DRAIN;
          end
        end else if (req_done) begin
          inst_d  = mem.mem_rdata;
          state_d = READY;
        end
      end

      DRAIN: begin
        if (trap_take) begin
          pc_d = trap_pc;
        end
        if (req_done) begin
          req_addr_d = trap_take ? trap_pc : pc;
          state_d    = FETCH;
        end
      end

      READY: begin
        if (trap_take) begin
          pc_d       = trap_pc;
          req_addr_d = trap_pc;
          state_d    = FETCH;
        end else if (advance) begin
          if (ialign) begin
            ialign_fault = !rst;
          end else begin
            pc_d       = next_pc;
            req_addr_d = next_pc;
            state_d    = halt_req ? HALTED : FETCH;
          end
        end else if (halt_req) begin
          state_d = HALTED;
        end
      end

      HALTED: begin
        if (dpc_we) begin
          pc_d = dpc_aligned;
        end
        if (resume_req) begin
          req_addr_d = dpc_we ? dpc_aligned : pc;
          state_d    = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= ResetVector;
      req_addr     <= ResetVector;
      inst         <= '0;
      mem_req_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      req_addr     <= req_addr_d;
      inst         <= inst_d;
      mem_req_q    <= (state_d == FETCH) || (state_d == DRAIN);
      inst_valid_q <= (state_d == READY);
      halted_q     <= (state_d == HALTED);
    end
  end

endmodule
